// File: rtl/ddr3_cmd_timer_pkg.sv
// DDR3 command encodings and ns/ps to clock-cycle helpers shared by the command timer.
// Pure definitions: no latency, no flow control.
package ddr3_cmd_timer_pkg;

   typedef enum logic [2:0] {
      CMD_MODE = 3'b000,
      CMD_REFR = 3'b001,
      CMD_PREC = 3'b010,
      CMD_ACTV = 3'b011,
      CMD_WRIT = 3'b100,
      CMD_READ = 3'b101,
      CMD_ZQCL = 3'b110,
      CMD_NOOP = 3'b111
   } cmd_e;

   localparam int PENDING_MAX = 8;

   // ceil(ns * MHz / 1000), taken in picoseconds so fractional-ns JEDEC values stay exact.
   function automatic int ps_to_cyc(input longint ps, input int mhz);
      return int'((ps * longint'(mhz) + longint'(999_999)) / longint'(1_000_000));
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ddr3_refresh_timer.sv
// Periodic-refresh interval counter with a saturating count of owed REFRESH commands.
// ref_due follows the registered pending count; no backpressure, ref_done is a one-cycle pulse.
module ddr3_refresh_timer
   import ddr3_cmd_timer_pkg::*;
#(
   parameter int TREFI = 780
) (
   input  logic clock,
   input  logic arst_n,
   input  logic en,
   input  logic ref_done,
   output logic ref_due
);

   localparam int CW = $clog2(TREFI + 1);
   localparam int PW = $clog2(PENDING_MAX + 1);

   logic [CW-1:0] cnt;
   logic [PW-1:0] pending;
   logic          expire;

   assign expire  = en && (cnt == CW'(TREFI - 1));
   assign ref_due = (pending != '0);

   always_ff @(posedge clock or negedge arst_n) begin
      if (!arst_n) begin
         cnt     <= '0;
         pending <= '0;
      end else if (!en) begin
         cnt     <= '0;
         pending <= '0;
      end else begin
         cnt <= expire ? '0 : cnt + CW'(1);
         // An expiry coinciding with a REFRESH cancels out.
         if (expire && !ref_done) begin
            if (pending != PW'(PENDING_MAX))
               pending <= pending + PW'(1);
         end else if (ref_done && !expire) begin
            if (pending != '0)
               pending <= pending - PW'(1);
         end
      end
   end

endmodule

// File: rtl/ddr3_cmd_timer.sv
// Gates scheduler commands onto the DFI pins once all DDR3 minimum gaps have elapsed; 1-cycle pin latency.
// ddl_rdy_o is held low (from registered counters only) until the presented command is legal.
module ddr3_cmd_timer
   import ddr3_cmd_timer_pkg::*;
#(
   parameter int DDR_FREQ_MHZ = 100,
   parameter int DDR_ROW_BITS = 13,
   parameter int CWL          = 5,
   parameter int TRCD         = ps_to_cyc(13750, DDR_FREQ_MHZ),
   parameter int TRP          = ps_to_cyc(13750, DDR_FREQ_MHZ),
   parameter int TRAS         = ps_to_cyc(35000, DDR_FREQ_MHZ),
   parameter int TRC          = ps_to_cyc(48750, DDR_FREQ_MHZ),
   parameter int TCCD         = 4,
   parameter int TRTP         = max_int(4, ps_to_cyc(7500, DDR_FREQ_MHZ)),
   parameter int TWR          = ps_to_cyc(15000, DDR_FREQ_MHZ),
   parameter int TRFC         = ps_to_cyc(110000, DDR_FREQ_MHZ),
   parameter int TMOD         = max_int(12, ps_to_cyc(15000, DDR_FREQ_MHZ)),
   parameter int TZQ          = 512,
   parameter int TREFI        = ps_to_cyc(7800000, DDR_FREQ_MHZ)
) (
   input  logic                    clock,
   input  logic                    arst_n,
   input  logic                    ref_en_i,
   input  logic                    ddl_req_i,
   input  logic                    ddl_seq_i,
   input  logic [2:0]              ddl_cmd_i,
   input  logic [2:0]              ddl_ba_i,
   input  logic [DDR_ROW_BITS-1:0] ddl_adr_i,
   output logic                    ddl_rdy_o,
   output logic                    ddl_ref_o,
   output logic                    dfi_cs_n_o,
   output logic                    dfi_ras_n_o,
   output logic                    dfi_cas_n_o,
   output logic                    dfi_we_n_o,
   output logic [2:0]              dfi_ba_o,
   output logic [DDR_ROW_BITS-1:0] dfi_adr_o
);

   // Auto-precharge variants must cover the implied precharge before the next command.
   localparam int D_RDA = TRTP + TRP;
   localparam int D_WRA = CWL + 4 + TWR + TRP;
   localparam int D_MAX = max_int(max_int(max_int(TRCD, TCCD), max_int(D_RDA, D_WRA)),
                                  max_int(max_int(TRP, TRFC), max_int(TMOD, TZQ)));
   localparam int GW    = $clog2(D_MAX + 1);
   localparam int RW    = $clog2(max_int(TRAS, TRC) + 1);

   cmd_e          cmd;
   logic          accept;
   logic          ref_done;
   logic          unused_seq;
   logic [GW-1:0] gap;
   logic [GW-1:0] gap_load;
   logic [RW-1:0] tras;
   logic [RW-1:0] trc;
   int            dly;

   assign cmd        = cmd_e'(ddl_cmd_i);
   assign unused_seq = ddl_seq_i;
   assign ddl_rdy_o  = (gap == '0)
                       && !(cmd == CMD_PREC && tras != '0)
                       && !(cmd == CMD_ACTV && trc != '0);
   assign accept     = ddl_req_i && ddl_rdy_o;
   assign ref_done   = accept && (cmd == CMD_REFR);

   always_comb begin
      dly = 0;
      case (cmd)
         CMD_ACTV: dly = TRCD;
         CMD_READ: dly = ddl_adr_i[10] ? D_RDA : TCCD;
         CMD_WRIT: dly = ddl_adr_i[10] ? D_WRA : TCCD;
         CMD_PREC: dly = TRP;
         CMD_REFR: dly = TRFC;
         CMD_MODE: dly = TMOD;
         CMD_ZQCL: dly = TZQ;
         default:  dly = 0;
      endcase
      gap_load = (dly == 0) ? '0 : GW'(dly - 1);
   end

   always_ff @(posedge clock or negedge arst_n) begin
      if (!arst_n) begin
         gap  <= '0;
         tras <= '0;
         trc  <= '0;
      end else begin
         if (accept)
            gap <= gap_load;
         else if (gap != '0)
            gap <= gap - GW'(1);

         if (accept && cmd == CMD_ACTV) begin
            tras <= RW'(TRAS - 1);
            trc  <= RW'(TRC - 1);
         end else begin
            if (tras != '0) tras <= tras - RW'(1);
            if (trc != '0)  trc  <= trc - RW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge arst_n) begin
      if (!arst_n) begin
         dfi_cs_n_o  <= 1'b1;
         dfi_ras_n_o <= 1'b1;
         dfi_cas_n_o <= 1'b1;
         dfi_we_n_o  <= 1'b1;
         dfi_ba_o    <= '0;
         dfi_adr_o   <= '0;
      end else if (accept) begin
         dfi_cs_n_o                              <= (cmd == CMD_NOOP);
         {dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} <= ddl_cmd_i;
         dfi_ba_o                                <= ddl_ba_i;
         dfi_adr_o                               <= ddl_adr_i;
      end else begin
         dfi_cs_n_o                              <= 1'b1;
         {dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} <= CMD_NOOP;
      end
   end

   ddr3_refresh_timer #(
      .TREFI (TREFI)
   ) u_refresh (
      .clock    (clock),
      .arst_n   (arst_n),
      .en       (ref_en_i),
      .ref_done (ref_done),
      .ref_due  (ddl_ref_o)
   );

endmodule

// File: tb/tb_ddr3_cmd_timer.sv
// Scoreboarded bench for ddr3_cmd_timer: command gaps, pin encoding, refresh bookkeeping, async reset.
module tb_ddr3_cmd_timer;

   localparam int ROW = 13;

   logic           clock;
   logic           arst_n;
   logic           ref_en_i;
   logic           ddl_req_i;
   logic           ddl_seq_i;
   logic [2:0]     ddl_cmd_i;
   logic [2:0]     ddl_ba_i;
   logic [ROW-1:0] ddl_adr_i;
   logic           ddl_rdy_o;
   logic           ddl_ref_o;
   logic           dfi_cs_n_o;
   logic           dfi_ras_n_o;
   logic           dfi_cas_n_o;
   logic           dfi_we_n_o;
   logic [2:0]     dfi_ba_o;
   logic [ROW-1:0] dfi_adr_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [19:0] exp_q [$];

   // Delay table: command, auto-precharge bit, expected minimum spacing in cycles.
   logic [2:0] g_cmd [0:7] = '{3'b011, 3'b101, 3'b101, 3'b100, 3'b100, 3'b010, 3'b001, 3'b000};
   logic       g_ap  [0:7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   int         g_dly [0:7] = '{2, 4, 6, 4, 13, 2, 11, 12};

   ddr3_cmd_timer dut (
      .clock       (clock),
      .arst_n      (arst_n),
      .ref_en_i    (ref_en_i),
      .ddl_req_i   (ddl_req_i),
      .ddl_seq_i   (ddl_seq_i),
      .ddl_cmd_i   (ddl_cmd_i),
      .ddl_ba_i    (ddl_ba_i),
      .ddl_adr_i   (ddl_adr_i),
      .ddl_rdy_o   (ddl_rdy_o),
      .ddl_ref_o   (ddl_ref_o),
      .dfi_cs_n_o  (dfi_cs_n_o),
      .dfi_ras_n_o (dfi_ras_n_o),
      .dfi_cas_n_o (dfi_cas_n_o),
      .dfi_we_n_o  (dfi_we_n_o),
      .dfi_ba_o    (dfi_ba_o),
      .dfi_adr_o   (dfi_adr_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [19:0] expect_pins(input logic [2:0] c, input logic [2:0] b,
                                               input logic [ROW-1:0] a);
      return {(c == 3'b111), c, b, a};
   endfunction

   function automatic logic [19:0] pins();
      return {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o, dfi_ba_o, dfi_adr_o};
   endfunction

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) next_cycle();
   endtask

   // Present a command from posedge+1, wait (bounded) for rdy, and score the pins after acceptance.
   task automatic issue(input logic [2:0] c, input logic [2:0] b, input logic [ROW-1:0] a,
                        input int limit, output int waited);
      logic [19:0] exp_pins;
      logic [19:0] got;
      waited    = 0;
      ddl_req_i = 1'b1;
      ddl_cmd_i = c;
      ddl_ba_i  = b;
      ddl_adr_i = a;
      @(negedge clock);
      while (!ddl_rdy_o && waited < limit) begin
         waited++;
         @(negedge clock);
      end
      if (!ddl_rdy_o) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: cmd %b not accepted within %0d cycles", c, limit);
         next_cycle();
         ddl_req_i = 1'b0;
         ddl_cmd_i = 3'b111;
      end else begin
         exp_q.push_back(expect_pins(c, b, a));
         next_cycle();
         ddl_req_i = 1'b0;
         ddl_cmd_i = 3'b111;
         exp_pins  = exp_q.pop_front();
         got       = pins();
         checks++;
         if (got !== exp_pins) begin
            errors++;
            $display("FAIL pins_cmd_%b: got %h expected %h", c, got, exp_pins);
         end
      end
   endtask

   task automatic test_reset();
      checks++; if (dfi_cs_n_o !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", dfi_cs_n_o); end
      checks++; if ({dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} !== 3'b111) begin errors++;
         $display("FAIL reset_cmd_pins: got %b expected 111", {dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}); end
      checks++; if (dfi_ba_o !== 3'd0) begin errors++; $display("FAIL reset_ba: got %h expected 0", dfi_ba_o); end
      checks++; if (dfi_adr_o !== '0) begin errors++; $display("FAIL reset_adr: got %h expected 0", dfi_adr_o); end
      checks++; if (ddl_ref_o !== 1'b0) begin errors++; $display("FAIL reset_ref: got %b expected 0", ddl_ref_o); end
      checks++; if (ddl_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", ddl_rdy_o); end
   endtask

   task automatic test_act_wr();
      int w;
      issue(3'b011, 3'd2, 13'h0123, 50, w);
      checks++; if (w !== 0) begin errors++; $display("FAIL act_wait: got %0d expected 0", w); end
      issue(3'b100, 3'd2, 13'h0040, 50, w);
      checks++; if (w !== 1) begin errors++; $display("FAIL act_to_wr_wait: got %0d expected 1", w); end
      next_cycle();
      checks++; if ({dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} !== 4'b1111) begin errors++;
         $display("FAIL idle_pins: got %b expected 1111", {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}); end
      checks++; if ({dfi_ba_o, dfi_adr_o} !== {3'd2, 13'h0040}) begin errors++;
         $display("FAIL hold_ba_adr: got %h expected %h", {dfi_ba_o, dfi_adr_o}, {3'd2, 13'h0040}); end
   endtask

   task automatic test_wra_to_act();
      int w;
      idle(10);
      issue(3'b100, 3'd1, 13'h0400, 50, w);
      checks++; if (w !== 0) begin errors++; $display("FAIL wra_wait: got %0d expected 0", w); end
      issue(3'b011, 3'd1, 13'h0777, 50, w);
      checks++; if (w !== 12) begin errors++; $display("FAIL wra_to_act_wait: got %0d expected 12", w); end
   endtask

   task automatic test_act_pre_act();
      int w;
      idle(20);
      issue(3'b011, 3'd3, 13'h0010, 50, w);
      checks++; if (w !== 0) begin errors++; $display("FAIL apa_act_wait: got %0d expected 0", w); end
      next_cycle();
      issue(3'b010, 3'd3, 13'h0000, 50, w);
      checks++; if (w !== 2) begin errors++; $display("FAIL tras_pre_wait: got %0d expected 2", w); end
      issue(3'b011, 3'd3, 13'h0020, 50, w);
      checks++; if (w !== 1) begin errors++; $display("FAIL trc_trp_act_wait: got %0d expected 1", w); end
   endtask

   task automatic test_cmd_gaps();
      int w;
      logic [ROW-1:0] a;
      for (int i = 0; i < 8; i++) begin
         idle(20);
         a     = 13'h0012;
         a[10] = g_ap[i];
         issue(g_cmd[i], 3'd4, a, 50, w);
         checks++; if (w !== 0) begin errors++; $display("FAIL gap_first_%0d: got %0d expected 0", i, w); end
         issue(3'b111, 3'd4, a, 50, w);
         checks++; if (w !== g_dly[i] - 1) begin errors++;
            $display("FAIL gap_cmd_%b_ap%0d: got %0d expected %0d", g_cmd[i], g_ap[i], w, g_dly[i] - 1); end
      end
   endtask

   task automatic test_refresh();
      int w;
      int n;
      int c0;
      idle(20);
      c0       = cyc;
      ref_en_i = 1'b1;
      n        = 0;
      @(negedge clock);
      while (!ddl_ref_o && n < 2000) begin
         n++;
         @(negedge clock);
      end
      checks++; if (n !== 780) begin errors++; $display("FAIL trefi_rise: got %0d cycles expected 780", n); end
      next_cycle();
      issue(3'b001, 3'd0, 13'h0000, 50, w);
      checks++; if (ddl_ref_o !== 1'b0) begin errors++; $display("FAIL ref_clear: got %b expected 0", ddl_ref_o); end
      issue(3'b111, 3'd0, 13'h0000, 50, w);
      checks++; if (w !== 10) begin errors++; $display("FAIL trfc_wait: got %0d expected 10", w); end
      // Ten more expiries with no REFRESH; align just after one so no expiry lands among the REFs.
      while (cyc < c0 + 780 * 11) next_cycle();
      for (int i = 1; i <= 8; i++) begin
         issue(3'b001, 3'd0, 13'h0000, 50, w);
         checks++; if (ddl_ref_o !== (i < 8)) begin errors++;
            $display("FAIL pending_sat_ref_%0d: got %b expected %b", i, ddl_ref_o, (i < 8)); end
      end
      ref_en_i = 1'b0;
      next_cycle();
   endtask

   task automatic test_reset_mid();
      int w;
      idle(20);
      issue(3'b110, 3'd5, 13'h0400, 50, w);
      checks++; if (dfi_cs_n_o !== 1'b0) begin errors++; $display("FAIL zq_on_pins: got cs_n %b expected 0", dfi_cs_n_o); end
      checks++; if (ddl_rdy_o !== 1'b0) begin errors++; $display("FAIL zq_gap_rdy: got %b expected 0", ddl_rdy_o); end
      #1 arst_n = 1'b0;
      #1;
      checks++; if (pins() !== {4'b1111, 3'd0, 13'h0000}) begin errors++;
         $display("FAIL async_reset_pins: got %h expected %h", pins(), {4'b1111, 3'd0, 13'h0000}); end
      checks++; if (ddl_rdy_o !== 1'b1) begin errors++; $display("FAIL async_reset_rdy: got %b expected 1", ddl_rdy_o); end
      exp_q.delete();
      next_cycle();
      arst_n    = 1'b1;
      ddl_cmd_i = 3'b011;
      @(negedge clock);
      checks++; if (ddl_rdy_o !== 1'b1) begin errors++; $display("FAIL post_reset_rdy: got %b expected 1", ddl_rdy_o); end
      checks++; if (dfi_cs_n_o !== 1'b1) begin errors++; $display("FAIL post_reset_cs_n: got %b expected 1", dfi_cs_n_o); end
      ddl_cmd_i = 3'b111;
      next_cycle();
   endtask

   initial begin
      arst_n    = 1'b0;
      ref_en_i  = 1'b0;
      ddl_req_i = 1'b0;
      ddl_seq_i = 1'b0;
      ddl_cmd_i = 3'b111;
      ddl_ba_i  = 3'd0;
      ddl_adr_i = '0;
      idle(3);
      arst_n = 1'b1;
      #1;
      test_reset();
      next_cycle();
      test_act_wr();
      test_wra_to_act();
      test_act_pre_act();
      test_cmd_gaps();
      test_refresh();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
